// File: rtl/rv523_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv523_pkg
// Brief   : Shared constants and elaboration helpers for the RV523 storage cells.
// Revision: 1.0 - initial release
// ============================================================================
package rv523_pkg;

  localparam int RV523_XLEN = 32;
  localparam int RV523_NREG = 32;

  // Ceiling log2. Returns 0 for values of 0 or 1; callers clamp as needed.
  function automatic int rv523_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv523_regfile_regword.sv
`default_nettype none
// ============================================================================
// Module  : rv523_regword
// Brief   : One register-file row: WIDTH enable-flops with async active-low clear.
// Revision: 1.0 - initial release
// ============================================================================
module rv523_regword
  import rv523_pkg::*;
#(
  parameter int WIDTH = RV523_XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  assign word_d = en ? d : word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule
`default_nettype wire

// File: rtl/rv523_regfile.sv
`default_nettype none
// ============================================================================
// Module  : rv523_regfile
// Brief   : Parametrised multi-port register file with optional x0, bypass and
//           registered read ports.
// Revision: 1.0 - initial release
// ============================================================================
module rv523_regfile
  import rv523_pkg::*;
#(
  parameter int WIDTH     = RV523_XLEN,
  parameter int DEPTH     = RV523_NREG,
  parameter int NREAD     = 2,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1,
  parameter bit SYNC_READ = 1'b0,
  localparam int AW       = (rv523_clog2(DEPTH) < 1) ? 1 : rv523_clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       re,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata
);

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] c_depth_w = (AW + 1)'(DEPTH);

  logic             w_wr_legal;
  logic [WIDTH-1:0] w_rows [DEPTH];

  assign w_wr_legal = we
                    && ({1'b0, waddr} < c_depth_w)
                    && !(ZERO_REG && (waddr == '0));

  genvar r;
  generate
    for (r = 0; r < DEPTH; r++) begin : g_row
      if (ZERO_REG && (r == 0)) begin : g_zero
        assign w_rows[r] = '0;
      end else begin : g_word
        logic w_en;
        assign w_en = w_wr_legal && (waddr == AW'(r));

        rv523_regword #(
          .WIDTH (WIDTH)
        ) u_word (
          .clk   (clk),
          .rst_n (rst_n),
          .en    (w_en),
          .d     (wdata),
          .q     (w_rows[r])
        );
      end
    end
  endgenerate

  genvar p;
  generate
    for (p = 0; p < NREAD; p++) begin : g_rd
      logic [AW-1:0]    w_ra;
      logic [WIDTH-1:0] w_rd;

      assign w_ra = raddr[p*AW +: AW];

      // Out-of-range addresses read as zero; row 0 is already zero when hardwired.
      always_comb begin
        w_rd = '0;
        if ({1'b0, w_ra} < c_depth_w) begin
          w_rd = w_rows[w_ra];
        end
        if (BYPASS && w_wr_legal && (waddr == w_ra)) begin
          w_rd = wdata;
        end
      end

      if (SYNC_READ) begin : g_sync
        logic [WIDTH-1:0] rd_q;
        logic [WIDTH-1:0] rd_d;

        assign rd_d = re[p] ? w_rd : rd_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rd_q <= '0;
          end else begin
            rd_q <= rd_d;
          end
        end

        assign rdata[p*WIDTH +: WIDTH] = rd_q;
      end else begin : g_comb
        logic unused_re;
        assign unused_re = re[p];
        assign rdata[p*WIDTH +: WIDTH] = w_rd;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rv523_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv523_regfile
// Brief   : Scoreboard bench covering default, no-bypass, odd-depth and
//           registered-read configurations of rv523_regfile.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv523_regfile;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default configuration
  logic        d_we;
  logic [4:0]  d_waddr;
  logic [31:0] d_wdata;
  logic [1:0]  d_re;
  logic [9:0]  d_raddr;
  logic [63:0] d_rdata;
  // BYPASS = 0
  logic        b_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [1:0]  b_re;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  // DEPTH = 24
  logic        z_we;
  logic [4:0]  z_waddr;
  logic [31:0] z_wdata;
  logic [1:0]  z_re;
  logic [9:0]  z_raddr;
  logic [63:0] z_rdata;
  // SYNC_READ = 1, NREAD = 3
  logic        s_we;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [2:0]  s_re;
  logic [14:0] s_raddr;
  logic [95:0] s_rdata;

  rv523_regfile u_def (
    .clk(clk), .rst_n(rst_n), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
    .re(d_re), .raddr(d_raddr), .rdata(d_rdata)
  );

  rv523_regfile #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .rdata(b_rdata)
  );

  rv523_regfile #(.DEPTH(24)) u_d24 (
    .clk(clk), .rst_n(rst_n), .we(z_we), .waddr(z_waddr), .wdata(z_wdata),
    .re(z_re), .raddr(z_raddr), .rdata(z_rdata)
  );

  rv523_regfile #(.NREAD(3), .SYNC_READ(1'b1)) u_sync (
    .clk(clk), .rst_n(rst_n), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .re(s_re), .raddr(s_raddr), .rdata(s_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  string       sb_tag [$];
  logic [31:0] sb_exp [$];

  task automatic sb_push(input string t, input logic [31:0] e);
    sb_tag.push_back(t);
    sb_exp.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    t = sb_tag.pop_front();
    e = sb_exp.pop_front();
    chk(t, obs, e);
  endtask

  function automatic logic [31:0] d_port(input int p);
    return d_rdata[p*32 +: 32];
  endfunction
  function automatic logic [31:0] b_port(input int p);
    return b_rdata[p*32 +: 32];
  endfunction
  function automatic logic [31:0] z_port(input int p);
    return z_rdata[p*32 +: 32];
  endfunction
  function automatic logic [31:0] s_port(input int p);
    return s_rdata[p*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mdl [32];

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    d_we = 0; d_waddr = 0; d_wdata = 0; d_re = 0; d_raddr = {5'd0, 5'd5};
    b_we = 0; b_waddr = 0; b_wdata = 0; b_re = 0; b_raddr = 0;
    z_we = 0; z_waddr = 0; z_wdata = 0; z_re = 0; z_raddr = 0;
    s_we = 0; s_waddr = 0; s_wdata = 0; s_re = 0; s_raddr = 0;
    #12;
    sb_push("rst_d_p0", 32'h0);
    sb_push("rst_d_p1", 32'h0);
    sb_push("rst_s_p0", 32'h0);
    sb_pop(d_port(0));
    sb_pop(d_port(1));
    sb_pop(s_port(0));

    // Release between edges; the very next edge must accept the write.
    rst_n = 1'b1;
    d_we = 1; d_waddr = 5; d_wdata = 32'hDEADBEEF;
    tick();
    d_we = 0; d_raddr[4:0] = 5;
    sb_push("first_write_r5", 32'hDEADBEEF);
    #1 sb_pop(d_port(0));

    // Asynchronous clear with no clock edge in the window.
    rst_n = 1'b0;
    sb_push("async_rst_r5", 32'h0);
    #1 sb_pop(d_port(0));
    #2 rst_n = 1'b1;

    // Reset held across an edge while writing r6.
    rst_n = 1'b0;
    d_we = 1; d_waddr = 6; d_wdata = 32'hCAFEF00D;
    tick();
    rst_n = 1'b1;
    d_we = 0; d_raddr[4:0] = 6;
    sb_push("rst_mid_write_r6", 32'h0);
    #1 sb_pop(d_port(0));
    tick();
    sb_push("rst_mid_write_r6_later", 32'h0);
    sb_pop(d_port(0));

    // Plain write, both ports on the same register.
    d_we = 1; d_waddr = 7; d_wdata = 32'h12345678;
    tick();
    d_we = 0; d_raddr = {5'd7, 5'd7};
    sb_push("r7_p0", 32'h12345678);
    sb_push("r7_p1", 32'h12345678);
    #1;
    sb_pop(d_port(0));
    sb_pop(d_port(1));

    // x0 is neither writable nor forwarded.
    d_we = 1; d_waddr = 0; d_wdata = 32'hFFFFFFFF; d_raddr = {5'd0, 5'd0};
    sb_push("x0_no_bypass", 32'h0);
    #1 sb_pop(d_port(0));
    tick();
    d_we = 0;
    sb_push("x0_read", 32'h0);
    #1 sb_pop(d_port(1));

    // Bypass on vs off.
    d_we = 1; d_waddr = 3; d_wdata = 32'h1;
    b_we = 1; b_waddr = 3; b_wdata = 32'h1;
    tick();
    d_wdata = 32'hA5A5A5A5; d_raddr[4:0] = 3;
    b_wdata = 32'hA5A5A5A5; b_raddr[4:0] = 3;
    sb_push("bypass_on_pre", 32'hA5A5A5A5);
    sb_push("bypass_off_pre", 32'h1);
    #1;
    sb_pop(d_port(0));
    sb_pop(b_port(0));
    tick();
    d_we = 0; b_we = 0;
    sb_push("bypass_off_post", 32'hA5A5A5A5);
    sb_push("bypass_on_post", 32'hA5A5A5A5);
    #1;
    sb_pop(b_port(0));
    sb_pop(d_port(0));

    // DEPTH=24: out-of-range write and read.
    z_we = 1; z_waddr = 30; z_wdata = 32'h55; z_raddr[4:0] = 30;
    sb_push("d24_oor_no_bypass", 32'h0);
    #1 sb_pop(z_port(0));
    tick();
    z_waddr = 23; z_wdata = 32'h23;
    tick();
    z_we = 0; z_raddr = {5'd23, 5'd30};
    sb_push("d24_r30", 32'h0);
    sb_push("d24_r23", 32'h23);
    #1;
    sb_pop(z_port(0));
    sb_pop(z_port(1));
    z_raddr = {5'd14, 5'd6};
    sb_push("d24_alias_r6", 32'h0);
    sb_push("d24_alias_r14", 32'h0);
    #1;
    sb_pop(z_port(0));
    sb_pop(z_port(1));

    // Registered read ports.
    s_we = 1; s_waddr = 2; s_wdata = 32'h22;
    tick();
    s_waddr = 4; s_wdata = 32'h44;
    tick();
    s_we = 0; s_re = 3'b010; s_raddr = {5'd0, 5'd2, 5'd0};
    sb_push("sync_p1_latency", 32'h0);
    #1 sb_pop(s_port(1));
    tick();
    sb_push("sync_p1_load", 32'h22);
    sb_pop(s_port(1));
    s_re = 3'b101; s_raddr = {5'd2, 5'd9, 5'd4};
    sb_push("sync_p0_latency", 32'h0);
    #1 sb_pop(s_port(0));
    tick();
    sb_push("sync_p0", 32'h44);
    sb_push("sync_p1_held", 32'h22);
    sb_push("sync_p2", 32'h22);
    sb_pop(s_port(0));
    sb_pop(s_port(1));
    sb_pop(s_port(2));
    s_re = 3'b000; s_we = 1; s_waddr = 4; s_wdata = 32'h99;
    tick();
    s_we = 0;
    sb_push("sync_hold_p0", 32'h44);
    sb_pop(s_port(0));
    s_re = 3'b001;
    tick();
    sb_push("sync_reload_p0", 32'h99);
    sb_pop(s_port(0));
    s_we = 1; s_waddr = 4; s_wdata = 32'h77;
    tick();
    s_we = 0; s_re = 3'b000;
    sb_push("sync_bypass_p0", 32'h77);
    sb_pop(s_port(0));
    rst_n = 1'b0;
    sb_push("sync_async_rst_p0", 32'h0);
    #1 sb_pop(s_port(0));
    #1 rst_n = 1'b1;

    // Random traffic against a reference model on the default configuration.
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int it = 0; it < 40; it++) begin
      logic        we_r;
      logic [4:0]  wa, ra0, ra1;
      logic [31:0] wd, e0, e1;
      we_r = 1'($urandom_range(0, 1));
      wa   = 5'($urandom_range(0, 31));
      wd   = $urandom;
      ra0  = (it % 3 == 0) ? wa : 5'($urandom_range(0, 31));
      ra1  = 5'($urandom_range(0, 31));
      d_we = we_r; d_waddr = wa; d_wdata = wd; d_raddr = {ra1, ra0};
      e0 = mdl[ra0];
      e1 = mdl[ra1];
      if (we_r && wa != 5'd0 && wa == ra0) e0 = wd;
      if (we_r && wa != 5'd0 && wa == ra1) e1 = wd;
      sb_push("rand_p0", e0);
      sb_push("rand_p1", e1);
      #1;
      sb_pop(d_port(0));
      sb_pop(d_port(1));
      tick();
      if (we_r && wa != 5'd0) mdl[wa] = wd;
    end
    d_we = 0;

    chk("sb_drain", 32'(sb_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
